// File: rtl/walk_register_if.sv
// Bundle between the walk-button path, the walk request latch and the traffic-light controller.
interface walk_register_if #(
    parameter int COUNT_W = 4
);
    logic               WR_Sync;
    logic               WR_Reset;
    logic               WR;
    logic               WR_Set;
    logic [COUNT_W-1:0] WR_Count;

    modport master (
        output WR_Sync,
        output WR_Reset,
        input  WR,
        input  WR_Set,
        input  WR_Count
    );

    modport slave (
        input  WR_Sync,
        input  WR_Reset,
        output WR,
        output WR_Set,
        output WR_Count
    );
endinterface

// File: rtl/walk_register.sv
// Pedestrian walk-request latch: edge-detects the synchronised button, holds the request
// until the controller clears it, and counts accepted presses with saturation.
module walk_register #(
    parameter int COUNT_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    walk_register_if.slave wr_if
);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    logic               sync_q;
    logic               sync_d;
    logic               wr_q;
    logic               wr_d;
    logic               wr_set_q;
    logic               wr_set_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               press_s;

    // Next-state: clear beats press; a press during clear is dropped but sync still tracks.
    always_comb begin
        sync_d   = wr_if.WR_Sync;
        wr_d     = wr_q;
        wr_set_d = 1'b0;
        count_d  = count_q;
        press_s  = wr_if.WR_Sync & ~sync_q;
        if (wr_if.WR_Reset) begin
            wr_d     = 1'b0;
            wr_set_d = 1'b0;
            count_d  = {COUNT_W{1'b0}};
        end else if (press_s) begin
            wr_d     = 1'b1;
            wr_set_d = 1'b1;
            if (count_q != COUNT_MAX) begin
                count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_d = count_q;
            end
        end else begin
            wr_d     = wr_q;
            wr_set_d = 1'b0;
            count_d  = count_q;
        end
    end

    // State registers; sync_q resets high so a button held through reset is not a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 1'b1;
            wr_q     <= 1'b0;
            wr_set_q <= 1'b0;
            count_q  <= {COUNT_W{1'b0}};
        end else begin
            sync_q   <= sync_d;
            wr_q     <= wr_d;
            wr_set_q <= wr_set_d;
            count_q  <= count_d;
        end
    end

    assign wr_if.WR       = wr_q;
    assign wr_if.WR_Set   = wr_set_q;
    assign wr_if.WR_Count = count_q;
endmodule

// File: tb/tb_walk_register.sv
// Self-checking bench for walk_register: vector table, directed corner sequences and
// randomized traffic against a behavioural press/clear model.
module tb_walk_register;
    localparam int COUNT_W = 4;
    localparam int MAXC    = (1 << COUNT_W) - 1;

    typedef struct {
        bit sync;
        bit rst;
        bit exp_wr;
        bit exp_set;
        int exp_cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    bit m_prev;
    bit m_wr;
    bit m_set;
    int m_cnt;

    walk_register_if #(.COUNT_W(COUNT_W)) ifc ();

    walk_register #(.COUNT_W(COUNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_if (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 1'b1;
        m_wr   = 1'b0;
        m_set  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_edge(input bit s, input bit r);
        bit press;
        press = s && !m_prev;
        if (r) begin
            m_wr  = 1'b0;
            m_set = 1'b0;
            m_cnt = 0;
        end else if (press) begin
            m_wr  = 1'b1;
            m_set = 1'b1;
            m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
        end else begin
            m_set = 1'b0;
        end
        m_prev = s;
    endtask

    // Apply inputs, clock once, advance model, then settle away from the edge.
    task automatic step(input bit s, input bit r);
        ifc.WR_Sync  = s;
        ifc.WR_Reset = r;
        @(posedge clk);
        model_edge(s, r);
        #1;
    endtask

    task automatic chk_model(input string name);
        chk({name, ".WR"},       int'(ifc.WR),       int'(m_wr));
        chk({name, ".WR_Set"},   int'(ifc.WR_Set),   int'(m_set));
        chk({name, ".WR_Count"}, int'(ifc.WR_Count), m_cnt);
    endtask

    vec_t vecs[12];
    int   set_pulses;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};

        // Reset with the button held
        rst_n        = 1'b0;
        ifc.WR_Sync  = 1'b1;
        ifc.WR_Reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.WR",       int'(ifc.WR),       0);
        chk("reset.WR_Set",   int'(ifc.WR_Set),   0);
        chk("reset.WR_Count", int'(ifc.WR_Count), 0);
        #3 rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].sync, vecs[i].rst);
            chk($sformatf("vec%0d.WR", i),       int'(ifc.WR),       int'(vecs[i].exp_wr));
            chk($sformatf("vec%0d.WR_Set", i),   int'(ifc.WR_Set),   int'(vecs[i].exp_set));
            chk($sformatf("vec%0d.WR_Count", i), int'(ifc.WR_Count), vecs[i].exp_cnt);
        end

        // Single pulse then long idle: request must persist
        step(1'b1, 1'b0);
        chk("pulse.WR_Set", int'(ifc.WR_Set), 1);
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0);
            chk_model("hold");
        end
        chk("hold.WR", int'(ifc.WR), 1);
        step(1'b0, 1'b1);
        chk("clear.WR",       int'(ifc.WR),       0);
        chk("clear.WR_Count", int'(ifc.WR_Count), 0);

        // Long hold is a single press
        set_pulses = 0;
        step(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            if (ifc.WR_Set) set_pulses++;
        end
        step(1'b0, 1'b0);
        if (ifc.WR_Set) set_pulses++;
        chk("longhold.pulses",   set_pulses,          1);
        chk("longhold.WR_Count", int'(ifc.WR_Count), 1);
        step(1'b0, 1'b1);

        // Saturation: 17 separate presses
        set_pulses = 0;
        step(1'b0, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 1'b0);
            if (ifc.WR_Set) set_pulses++;
            if (i == 15) chk("sat.count15", int'(ifc.WR_Count), MAXC);
            step(1'b0, 1'b0);
            if (ifc.WR_Set) set_pulses++;
        end
        chk("sat.pulses",   set_pulses,          17);
        chk("sat.WR_Count", int'(ifc.WR_Count), MAXC);
        chk("sat.WR",       int'(ifc.WR),       1);
        step(1'b0, 1'b1);

        // Async reset between edges with count at 3
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        chk("pre_async.WR_Count", int'(ifc.WR_Count), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async.WR",       int'(ifc.WR),       0);
        chk("async.WR_Set",   int'(ifc.WR_Set),   0);
        chk("async.WR_Count", int'(ifc.WR_Count), 0);
        model_reset();
        #2 rst_n = 1'b1;
        step(1'b1, 1'b0);
        chk_model("post_async");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
            chk_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
